// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and hex-to-segment table for the
// seg7_scan_ctrl display scanner.
// Optional feature: SEG7_BLINK_EN adds a per-digit blink flag to the record.
package seg7_pkg;

  // Segment vector {g,f,e,d,c,b,a}, active-low; all ones means dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // One captured digit: nibble, decimal point and forced-blank flag.
  typedef struct packed {
`ifdef SEG7_BLINK_EN
    logic       blink;
`endif
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } digit_rec_t;

  // Active-low hex glyphs 0..F.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load/data inputs and multiplexed display outputs of the
// scanner. master = host/bench side, slave = seg7_scan_ctrl.
//   load      single-cycle capture request for data/dp_in/blank_in
//   data      4*DIGITS hex nibbles, digit 0 in [3:0]
//   dp_in     per-digit decimal point, 1 = lit
//   blank_in  per-digit forced blank, 1 = blank
//   lz_en     leading-zero suppression enable
//   bright    brightness code, 0 = dimmest
//   display_* segments/dp/anodes, all active-low
//   frame     one-cycle pulse on the full-scan boundary
//   pending   a captured load waits for the next frame boundary
// Optional feature: SEG7_BLINK_EN adds blink_in (captured with load).
interface seg7_scan_ctrl_if #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned BRIGHT_W = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]     blink_in;
`endif
  logic                  lz_en;
  logic [BRIGHT_W-1:0]   bright;
  logic [6:0]            display_c;
  logic                  display_dp;
  logic [DIGITS-1:0]     display_an;
  logic                  frame;
  logic                  pending;

  modport master (
`ifdef SEG7_BLINK_EN
    output blink_in,
`endif
    output load, data, dp_in, blank_in, lz_en, bright,
    input  display_c, display_dp, display_an, frame, pending
  );

  modport slave (
`ifdef SEG7_BLINK_EN
    input  blink_in,
`endif
    input  load, data, dp_in, blank_in, lz_en, bright,
    output display_c, display_dp, display_an, frame, pending
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to active-low segment decoder.
//   nib    hex digit in
//   seg_c  segments {g,f,e,d,c,b,a}, active-low
module seg7_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);
  import seg7_pkg::*;

  assign seg_c = hex2seg(nib);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous
// double-buffered loads, PWM brightness and leading-zero suppression.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       seg7_scan_ctrl_if.slave (load/data in, display/frame/pending out)
// Optional feature: define SEG7_BLINK_EN for per-digit blink (BLINK_FRAMES).
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BRIGHT_W = 3
`ifdef SEG7_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 256
`endif
) (
  input  logic           clk,
  input  logic           rst,
  seg7_scan_ctrl_if.slave bus
);
  import seg7_pkg::*;

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned WIN   = DIV >> BRIGHT_W;
  localparam int unsigned WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);

  // Slot counter is kept as (PWM window, cycle within window) so that no
  // divider is needed when DIV is not a power of two.
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [BRIGHT_W-1:0] win_idx_q, win_idx_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic                win_last, slot_last, idx_last, boundary_c;

  digit_rec_t [DIGITS-1:0] shadow_q, shadow_d, active_q, active_d, load_rec_c;
  digit_rec_t              cur_rec_c;
  logic                    pending_q, pending_d, frame_q, frame_d;

  logic [DIGITS-1:0] an_q, an_d, lz_mask;
  logic [6:0]        c_q, c_d, seg_c;
  logic              dp_q, dp_d, zero_run, pwm_on, suppress, blank;

`ifdef SEG7_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
`endif

  // Scan counters; frame_d flags that the next cycle is the boundary cycle.
  always_comb begin : cnt_next
    win_last   = (win_cnt_q == WIN_W'(WIN - 1));
    slot_last  = win_last && (win_idx_q == '1);
    idx_last   = (scan_idx_q == IDX_W'(DIGITS - 1));
    boundary_c = slot_last && idx_last;
    win_cnt_d  = win_last ? '0 : win_cnt_q + WIN_W'(1);
    win_idx_d  = win_last ? win_idx_q + BRIGHT_W'(1) : win_idx_q;
    scan_idx_d = scan_idx_q;
    if (slot_last) begin
      scan_idx_d = idx_last ? '0 : scan_idx_q + IDX_W'(1);
    end
    frame_d = (win_cnt_d == WIN_W'(WIN - 1)) && (win_idx_d == '1) &&
              (scan_idx_d == IDX_W'(DIGITS - 1));
  end

  // Pack the bus inputs into digit records.
  always_comb begin : pack_in
    load_rec_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_rec_c[i].hex   = bus.data[4*i +: 4];
      load_rec_c[i].dp    = bus.dp_in[i];
      load_rec_c[i].blank = bus.blank_in[i];
`ifdef SEG7_BLINK_EN
      load_rec_c[i].blink = bus.blink_in[i];
`endif
    end
  end

  // Double buffer: active only changes on the frame boundary.
  always_comb begin : load_next
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bus.load) begin
      if (boundary_c) begin
        active_d  = load_rec_c;
        pending_d = 1'b0;
      end else begin
        shadow_d  = load_rec_c;
        pending_d = 1'b1;
      end
    end else if (boundary_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  // Blink phase toggles every BLINK_FRAMES frame boundaries.
  always_comb begin : blink_next
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary_c) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end
`endif

  assign cur_rec_c = active_q[scan_idx_q];

  seg7_decode u_decode (
    .nib   (cur_rec_c.hex),
    .seg_c (seg_c)
  );

  // Pin values for the current counter state; a suppressed digit with its
  // decimal point set keeps its anode on so the point stays visible.
  always_comb begin : disp_next
    an_d     = '1;
    c_d      = SEG_OFF;
    dp_d     = 1'b1;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run   = zero_run && (active_q[i].hex == 4'h0);
      lz_mask[i] = zero_run;
    end
    pwm_on   = (win_idx_q <= bus.bright);
    suppress = bus.lz_en && lz_mask[scan_idx_q];
`ifdef SEG7_BLINK_EN
    blank    = cur_rec_c.blank || (blink_phase_q && cur_rec_c.blink);
`else
    blank    = cur_rec_c.blank;
`endif
    if (pwm_on && !blank) begin
      if (!suppress) begin
        an_d = ~(DIGITS'(1) << scan_idx_q);
        c_d  = seg_c;
        dp_d = ~cur_rec_c.dp;
      end else if (cur_rec_c.dp) begin
        an_d = ~(DIGITS'(1) << scan_idx_q);
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      win_cnt_q  <= '0;
      win_idx_q  <= '0;
      scan_idx_q <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      an_q       <= '1;
      c_q        <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_idx_q  <= win_idx_d;
      scan_idx_q <= scan_idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      c_q        <= c_d;
      dp_q       <= dp_d;
    end
  end

`ifdef SEG7_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin : blink_regs
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  assign bus.display_an = an_q;
  assign bus.display_c  = c_q;
  assign bus.display_dp = dp_q;
  assign bus.frame      = frame_q;
  assign bus.pending    = pending_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter CLK_HZ, default 100000000, input clock frequency.
REQ-003 SHALL have parameter SCAN_HZ, default 1000, digit-slot rate; DIV=CLK_HZ/SCAN_HZ cycles per slot, DIV multiple of 2^BRIGHT_W.
REQ-004 SHALL have parameter BRIGHT_W, default 3, brightness code width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: CLK  in  1  system clock; RST  in  1  async reset, active-high.
REQ-006 LOAD  in  1  single-cycle request to capture DATA/DP_IN/BLANK_IN.
REQ-007 DATA  in  4*DIGITS  hex nibbles, digit 0 (rightmost) in bits[3:0].
REQ-008 DP_IN  in  DIGITS  decimal point per digit, 1=lit.
REQ-009 BLANK_IN  in  DIGITS  per-digit forced blank, 1=blank.
REQ-010 LZ_EN  in  1  leading-zero suppression enable.
REQ-011 BRIGHT  in  BRIGHT_W  brightness, 0=dimmest, all-ones=full.
REQ-012 DISPLAY_C  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 DISPLAY_DP  out  1  decimal point, active-low.
REQ-014 DISPLAY_AN  out  DIGITS  digit enables, active-low, one-hot-low.
REQ-015 FRAME  out  1  one-cycle pulse at each full-scan boundary.
REQ-016 PENDING  out  1  high while a captured LOAD awaits frame boundary.

Function
REQ-017 Slot counter 0..DIV-1 wraps; on wrap, scan index advances 0->DIGITS-1->0.
REQ-018 Frame boundary = cycle where slot counter and scan index both wrap; FRAME=1 that cycle only.
REQ-019 LOAD copies inputs to shadow register, PENDING=1 next cycle; LOAD while PENDING overwrites shadow, last wins.
REQ-020 At frame boundary with PENDING=1: shadow -> active register, PENDING=0; display never mixes old and new frames.
REQ-021 LOAD in the boundary cycle: inputs go straight to active register, PENDING stays 0.
REQ-022 Slot split into 2^BRIGHT_W windows; AN active for first BRIGHT+1 windows, all outputs off otherwise.
REQ-023 Hex decode 0..F; e.g. 0=1000000, 1=1111001, 7=1111000, 8=0000000, F=0001110.
REQ-024 LZ_EN=1: zero digits from DIGITS-1 downward blanked until first nonzero; digit 0 never suppressed; DP still shown.
REQ-025 Blanked digit (BLANK_IN, suppression, PWM off): AN bit=1, C=7'h7F, DP=1.
REQ-026 Outputs registered: one-cycle latency from counter state to pins.

Reset
REQ-027 RST=1 SHALL immediately force AN all-ones, C=7'h7F, DP=1, FRAME=0, PENDING=0.
REQ-028 RST SHALL clear slot counter, scan index, shadow and active registers; first slot after release is digit 0.
REQ-029 RST mid-slot or mid-frame SHALL discard pending load.

Configuration
REQ-030 Macro SEG7_BLINK_EN defined: adds input BLINK_IN[DIGITS-1:0] and parameter BLINK_FRAMES (default 256); phase toggles every BLINK_FRAMES frames; flagged digits blanked in off phase; BLINK_IN captured with LOAD.
REQ-031 Macro undefined: no BLINK_IN port, no blink counter, behaviour as REQ-017..029.

Structure
REQ-032 Package seg7_pkg SHALL hold hex-to-segment function, SEG_OFF=7'h7F constant, digit-record type.
REQ-033 One sub-module seg7_decode (nibble -> segments) SHALL be instantiated; counters and registers stay in top.

Verification (params CLK_HZ=1600, SCAN_HZ=100, DIV=16, BRIGHT_W=3)
REQ-034 LOAD DATA=32'h01234567, BRIGHT=7 -> after next FRAME, digit-0 slot AN=8'b11111110, C=1111000 for 16/16 cycles.
REQ-035 LZ_EN=1, DATA=32'h00000A05 -> digits 7..3 AN=1; digit 1 shows 1000000; digit 0 shows 5.
REQ-036 BRIGHT=0 -> AN low 2 of 16 cycles per slot; BRIGHT=3 -> 8 of 16.
REQ-037 Two LOADs mid-frame -> PENDING=1, old values held until FRAME, then second LOAD's data shown, PENDING=0.
REQ-038 LOAD in FRAME cycle -> new data in next slot, PENDING never rises.
REQ-039 RST pulse mid-slot -> outputs blank same cycle; after release digit 0 scanned first, active data zero.
